// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// md_unit : E-stage multiply/divide unit holding HI/LO, with a busy flag.
//           Optional signed multiply-accumulate enabled by MDU_MADD_EN.
// Rev 1.0
// ============================================================================
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] c_OP_MULT  = 3'd0;
  localparam logic [2:0] c_OP_MULTU = 3'd1;
  localparam logic [2:0] c_OP_DIV   = 3'd2;
  localparam logic [2:0] c_OP_DIVU  = 3'd3;
  localparam logic [2:0] c_OP_MTHI  = 3'd4;
  localparam logic [2:0] c_OP_MTLO  = 3'd5;
`ifdef MDU_MADD_EN
  localparam logic [2:0] c_OP_MADD  = 3'd6;
`endif

  localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_n;
  logic        w_launch;
  logic        w_commit;
  logic        w_wr_hi;
  logic        w_wr_lo;
  logic        w_is_md;
  logic        w_is_mul;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_hi_n;
  logic [31:0] r_lo_n;
  logic        r_wr;

  // Arithmetic datapath
  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [31:0]        w_abs_a;
  logic [31:0]        w_abs_b;
  logic [31:0]        w_abs_b_nz;
  logic [31:0]        w_b_nz;
  logic [31:0]        w_qs_mag;
  logic [31:0]        w_rs_mag;
  logic [31:0]        w_qs;
  logic [31:0]        w_rs;
  logic [63:0]        w_res;
  logic               w_res_wr;

  assign w_prod_s = $signed(a) * $signed(b);
  assign w_prod_u = {32'h0, a} * {32'h0, b};

  // Signed division is done on magnitudes; this makes 0x80000000 / -1 fall
  // out naturally as quotient 0x80000000, remainder 0.
  assign w_abs_a    = a[31] ? (32'h0 - a) : a;
  assign w_abs_b    = b[31] ? (32'h0 - b) : b;
  assign w_abs_b_nz = (b == 32'h0) ? 32'h1 : w_abs_b;
  assign w_b_nz     = (b == 32'h0) ? 32'h1 : b;
  assign w_qs_mag   = w_abs_a / w_abs_b_nz;
  assign w_rs_mag   = w_abs_a % w_abs_b_nz;
  assign w_qs       = (a[31] ^ b[31]) ? (32'h0 - w_qs_mag) : w_qs_mag;
  assign w_rs       = a[31] ? (32'h0 - w_rs_mag) : w_rs_mag;

`ifdef MDU_MADD_EN
  assign w_is_md  = (mdop <= c_OP_DIVU) || (mdop == c_OP_MADD);
  assign w_is_mul = (mdop == c_OP_MULT) || (mdop == c_OP_MULTU) || (mdop == c_OP_MADD);
`else
  assign w_is_md  = (mdop <= c_OP_DIVU);
  assign w_is_mul = (mdop == c_OP_MULT) || (mdop == c_OP_MULTU);
`endif

  always_comb begin
    w_res    = w_prod_s;
    w_res_wr = 1'b1;
    case (mdop)
      c_OP_MULT:  w_res = w_prod_s;
      c_OP_MULTU: w_res = w_prod_u;
      c_OP_DIV: begin
        w_res    = {w_rs, w_qs};
        w_res_wr = (b != 32'h0);
      end
      c_OP_DIVU: begin
        w_res    = {a % w_b_nz, a / w_b_nz};
        w_res_wr = (b != 32'h0);
      end
`ifdef MDU_MADD_EN
      c_OP_MADD:  w_res = {r_hi, r_lo} + w_prod_s;
`endif
      default:    w_res = w_prod_s;
    endcase
  end

  // Next-state and control
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_launch  = 1'b0;
    w_commit  = 1'b0;
    w_wr_hi   = 1'b0;
    w_wr_lo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!req) begin
          if (start && w_is_md) begin
            w_launch  = 1'b1;
            w_cnt_n   = w_is_mul ? c_MULT_CNT : c_DIV_CNT;
            w_state_n = S_RUN;
          end else if (mdop == c_OP_MTHI) begin
            w_wr_hi = 1'b1;
          end else if (mdop == c_OP_MTLO) begin
            w_wr_lo = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == 4'd1) begin
          w_commit  = 1'b1;
          w_cnt_n   = 4'd0;
          w_state_n = S_IDLE;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi   <= 32'h0;
      r_lo   <= 32'h0;
      r_hi_n <= 32'h0;
      r_lo_n <= 32'h0;
      r_wr   <= 1'b0;
    end else begin
      if (w_launch) begin
        r_hi_n <= w_res[63:32];
        r_lo_n <= w_res[31:0];
        r_wr   <= w_res_wr;
      end
      // A divide by zero still runs its full latency but leaves HI/LO alone.
      if (w_commit && r_wr) begin
        r_hi <= r_hi_n;
        r_lo <= r_lo_n;
      end
      if (w_wr_hi) r_hi <= a;
      if (w_wr_lo) r_lo <= a;
    end
  end

  assign busy = (r_state == S_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// tb_md_unit : directed self-checking bench for md_unit with a reference model.
// Rev 1.0
// ============================================================================
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mdop  (mdop),
    .a     (a),
    .b     (b),
    .req   (req),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: results computed with 64-bit arithmetic, completion
  // scheduled by absolute edge number.
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;
  bit          pend = 1'b0;
  bit          pend_wr = 1'b0;
  logic [63:0] pend_val = 64'h0;
  int          edge_n = 0;
  int          done_edge = 0;
  bit          model_ok = 1'b0;

  function automatic logic [64:0] md_result(input logic [2:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] base);
    longint sx, sy, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    case (op)
      3'd0: return {1'b1, 64'(sx * sy)};
      3'd1: return {1'b1, ux * uy};
      3'd2: begin
        if (y == 32'h0) return {1'b0, 64'h0};
        q = sx / sy;
        r = sx % sy;
        return {1'b1, r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 32'h0) return {1'b0, 64'h0};
        return {1'b1, 32'(ux % uy), 32'(ux / uy)};
      end
      default: return {1'b1, base + 64'(sx * sy)};
    endcase
  endfunction

  always @(posedge clk) begin
    logic [64:0] res;
    edge_n++;
    if (!reset) begin
      m_hi = 32'h0;
      m_lo = 32'h0;
      pend = 1'b0;
      model_ok = 1'b1;
    end else if (pend) begin
      if (edge_n == done_edge) begin
        if (pend_wr) {m_hi, m_lo} = pend_val;
        pend = 1'b0;
      end
    end else if (!req) begin
      if (start && (mdop <= 3'd3 || (MADD && mdop == 3'd6))) begin
        res       = md_result(mdop, a, b, {m_hi, m_lo});
        pend      = 1'b1;
        pend_wr   = res[64];
        pend_val  = res[63:0];
        done_edge = edge_n + ((mdop == 3'd2 || mdop == 3'd3) ? DC : MC);
      end else if (mdop == 3'd4) begin
        m_hi = a;
      end else if (mdop == 3'd5) begin
        m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_busy", 32'(busy), 32'(pend));
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle();
    start = 1'b0;
    req   = 1'b0;
    mdop  = 3'd7;
    a     = 32'h0;
    b     = 32'h0;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] v);
    mdop = op;
    a    = v;
    tick();
    idle();
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int n,
                        input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1;
    mdop  = op;
    a     = x;
    b     = y;
    tick();
    idle();
    for (int i = 0; i < n; i++) begin
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      chk({nm, "_hold_hi"}, hi, prev_hi);
      chk({nm, "_hold_lo"}, lo, prev_lo);
      tick();
    end
    chk({nm, "_done"}, 32'(busy), 32'd0);
    chk({nm, "_hi"}, hi, exp_hi);
    chk({nm, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick(2);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 1'b1;
    tick();

    run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, MC, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    chk("model_pin_hi", m_hi, 32'hFFFFFFFF);
    chk("model_pin_lo", m_lo, 32'hFFFFFFFA);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MC,
           32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'h00000001);
    run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, DC,
           32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu0", 3'd3, 32'd7, 32'd0, DC,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, DC,
           32'hFFFFFFFF, 32'hFFFFFFFD, 32'h00000000, 32'h80000000);
    run_op("divu", 3'd3, 32'hFFFFFFF0, 32'd7, DC,
           32'h00000000, 32'h80000000, 32'h00000002, 32'h24924922);
    chk("model_pin_divu", m_lo, 32'h24924922);

    // mthi then mtlo back to back
    mdop = 3'd4; a = 32'h12345678;
    tick();
    chk("mthi_hi", hi, 32'h12345678);
    chk("mthi_busy", 32'(busy), 32'd0);
    mdop = 3'd5; a = 32'h9ABCDEF0;
    tick();
    idle();
    chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mtlo_busy", 32'(busy), 32'd0);

    // mtlo and a second start while a divide is running are both dropped
    start = 1'b1; mdop = 3'd2; a = 32'd100; b = 32'd7;
    tick();
    idle();
    tick();
    mt(3'd5, 32'h0BADF00D);
    start = 1'b1; mdop = 3'd0; a = 32'd5; b = 32'd5;
    tick();
    idle();
    chk("mtlo_busy_lo", lo, 32'h9ABCDEF0);
    tick(DC - 3);
    chk("divmt_busy", 32'(busy), 32'd0);
    chk("divmt_hi", hi, 32'd2);
    chk("divmt_lo", lo, 32'd14);

    // start under flush
    start = 1'b1; req = 1'b1; mdop = 3'd0; a = 32'd3; b = 32'd3;
    tick();
    idle();
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);

    // flush three cycles into a running multiply does not abort it
    start = 1'b1; mdop = 3'd0; a = 32'h00010000; b = 32'h00010000;
    tick();
    idle();
    tick(2);
    req = 1'b1; mdop = 3'd4; a = 32'hDEADBEEF;
    tick();
    idle();
    tick(MC - 3);
    chk("reqrun_busy", 32'(busy), 32'd0);
    chk("reqrun_hi", hi, 32'h1);
    chk("reqrun_lo", lo, 32'h0);

    // reset in the middle of a divide
    mt(3'd4, 32'h0000AAAA);
    start = 1'b1; mdop = 3'd2; a = 32'd50; b = 32'd5;
    tick();
    idle();
    tick(2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rstdiv_busy", 32'(busy), 32'd0);
    chk("rstdiv_hi", hi, 32'h0);
    chk("rstdiv_lo", lo, 32'h0);
    tick(DC + 2);
    chk("rstdiv_late_hi", hi, 32'h0);
    chk("rstdiv_late_lo", lo, 32'h0);

    // madd
    mt(3'd4, 32'h0);
    mt(3'd5, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
    run_op("madd", 3'd6, 32'd1, 32'd1, MC, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0);
`else
    start = 1'b1; mdop = 3'd6; a = 32'd1; b = 32'd1;
    tick();
    idle();
    chk("madd_off_busy", 32'(busy), 32'd0);
    tick(MC);
    chk("madd_off_hi", hi, 32'h0);
    chk("madd_off_lo", lo, 32'hFFFFFFFF);
`endif

    // reserved opcode is ignored
    start = 1'b1; mdop = 3'd7; a = 32'd9; b = 32'd9;
    tick();
    idle();
    chk("rsvd_busy", 32'(busy), 32'd0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
